onehot_decoder_seq: RTL and testbench
=====================================

# onehot_decoder_seq

Parametrised registered binary-to-one-hot decoder with three drive modes: hold, timed pulse, and auto-scan. It generalises the 2-to-4 enable decoder to 2^SEL_W outputs and adds a load handshake and internal sequencing. It sits between control logic and per-channel select/strobe lines, such as row drivers, chip selects and mux enables, where glitch-free registered one-hot outputs are required.

## Interface
- SEL_W, 2, select width; output count is 2^SEL_W (SEL_W >= 1)
- PULSE_LEN, 4, cycles an output stays high in PULSE mode (>= 1)
- DWELL, 8, cycles spent on each output in SCAN mode (>= 1)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  global enable; low forces outputs off
- mode  in  2  sampled on accepted load: 00 LEVEL, 01 PULSE, 10 SCAN, 11 CLEAR
- in  in  SEL_W  binary select (start index in SCAN)
- load  in  1  request valid; accepted when load && ready
- ready  out  1  combinational: en && state != PULSE
- out  out  2^SEL_W  registered one-hot outputs (all-zero when idle)
- out_idx  out  SEL_W  registered index of asserted bit; 0 when idle
- busy  out  1  registered; high in any state but IDLE
- wrap  out  1  registered one-cycle pulse on SCAN wrap to index 0

## Operation
- States: IDLE, HOLD, PULSE, SCAN. Every output register updates only on clk.
- In IDLE, out=0, out_idx=0, busy=0.
- An accepted load is decoded by its sampled mode:
  - LEVEL: out=1<<in, out_idx=in, go to HOLD.
  - PULSE: out=1<<in, pulse counter=PULSE_LEN-1, go to PULSE.
  - SCAN: out=1<<in, out_idx=in, dwell counter=DWELL-1, go to SCAN.
  - CLEAR: out=0, go to IDLE.
- HOLD: out is held indefinitely. A new load is accepted and replaces out and state per its mode.
- PULSE: ready=0 and loads are ignored. The counter decrements each cycle. On the cycle the counter is 0, the next edge gives out=0, out_idx=0 and IDLE.
- SCAN: when the dwell counter is 0, out_idx increments mod 2^SEL_W, out is rotated left by 1 and the counter reloads to DWELL-1. Otherwise the counter decrements. A load preempts SCAN; the load takes priority over the dwell step.
- wrap=1 for exactly the cycle in which out_idx first shows 0 after the step from 2^SEL_W-1. A scan started at index 0 does not assert wrap.
- en=0: the next edge gives IDLE, out=0, out_idx=0, counters=0, wrap=0. Loads are ignored while en=0 because ready=0. On the return to en=1 the block stays in IDLE.
- At most one bit of out is ever high.

## Timing
- Reset values: out=0, out_idx=0, busy=0, wrap=0, state IDLE, counters 0. ready=0 only while en=0.
- Latency: out, out_idx and busy reflect an accepted load one cycle later.
- A pulse is high for exactly PULSE_LEN cycles. The next load can be accepted on the cycle out returns to 0.
- Scan period is DWELL * 2^SEL_W cycles; each index is held exactly DWELL cycles.
- rst has priority over en and load. A mid-pulse or mid-scan rst gives the reset values on the next edge.
- load and en falling together: the drop of en wins and the load is not accepted (ready=0).

## Configuration
- DECODER_SCAN_EN defined: SCAN mode and the wrap output are implemented as above.
- DECODER_SCAN_EN undefined: no scan counter logic is built. mode=10 behaves as CLEAR, and wrap is tied to 0.

## Test plan
- Reset with SEL_W=2: assert rst for 2 cycles → out=0000, out_idx=0, busy=0, wrap=0, ready=1 (en=1).
- LEVEL: load in=2, mode=00 → next cycle out=0100, busy=1. Load in=3, mode=00 → out=1000. Load mode=11 → out=0000, busy=0.
- PULSE: load in=1, mode=01, PULSE_LEN=4 → out=0010 for exactly 4 cycles with ready=0 throughout and a load during the pulse ignored; then out=0000 and ready=1.
- SCAN: load in=2, mode=10, DWELL=8 → out=0100 for 8 cycles, then 1000, then 0001 with wrap=1 for 1 cycle, then 0010. Load in=0, mode=00 mid-scan → out=0001 and HOLD.
- Enable: en=0 during SCAN → next cycle out=0000, busy=0. Re-raise en → block remains IDLE.
- Config: with DECODER_SCAN_EN undefined, load mode=10 → out=0000, busy=0, wrap never asserted.

Source files
------------

// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with LEVEL/PULSE/SCAN/CLEAR load modes.
// Define DECODER_SCAN_EN to build SCAN mode and the wrap output.
module onehot_decoder_seq #(
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned DWELL     = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic [1:0]               i_mode,
  input  logic [SEL_W-1:0]         i_in,
  input  logic                     i_load,
  output logic                     o_ready,
  output logic [(1 << SEL_W)-1:0]  o_out,
  output logic [SEL_W-1:0]         o_out_idx,
  output logic                     o_busy,
  output logic                     o_wrap
);

  localparam int unsigned N       = 1 << SEL_W;
  localparam int unsigned CNT_MAX = (PULSE_LEN > DWELL) ? PULSE_LEN : DWELL;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [1:0] MODE_LEVEL = 2'b00;
  localparam logic [1:0] MODE_PULSE = 2'b01;
`ifdef DECODER_SCAN_EN
  localparam logic [1:0] MODE_SCAN  = 2'b10;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_PULSE = 2'd2,
    ST_SCAN  = 2'd3
  } state_t;

  state_t             r_state;
  logic [N-1:0]       r_out;
  logic [SEL_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               w_accept;
  logic [N-1:0]       w_onehot;

  // Loads are refused while disabled or while a pulse is in flight.
  assign o_ready   = i_en && (r_state != ST_PULSE);
  assign w_accept  = i_load && o_ready;
  assign w_onehot  = N'(1) << i_in;

  assign o_out     = r_out;
  assign o_out_idx = r_idx;
  assign o_busy    = r_busy;

  // Main sequencer: a load always wins over the pulse countdown or dwell step.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (w_accept) begin
      case (i_mode)
        MODE_LEVEL: begin
          r_state <= ST_HOLD;
          r_out   <= w_onehot;
          r_idx   <= i_in;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
        MODE_PULSE: begin
          r_state <= ST_PULSE;
          r_out   <= w_onehot;
          r_idx   <= i_in;
          r_cnt   <= CNT_W'(PULSE_LEN - 1);
          r_busy  <= 1'b1;
        end
`ifdef DECODER_SCAN_EN
        MODE_SCAN: begin
          r_state <= ST_SCAN;
          r_out   <= w_onehot;
          r_idx   <= i_in;
          r_cnt   <= CNT_W'(DWELL - 1);
          r_busy  <= 1'b1;
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_out   <= '0;
          r_idx   <= '0;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end else begin
      case (r_state)
        ST_PULSE: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
`ifdef DECODER_SCAN_EN
        ST_SCAN: begin
          if (r_cnt == '0) begin
            r_out <= {r_out[N-2:0], r_out[N-1]};
            r_idx <= r_idx + SEL_W'(1);
            r_cnt <= CNT_W'(DWELL - 1);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

`ifdef DECODER_SCAN_EN
  logic r_wrap;

  // Flags the single cycle where the scan index rolls from the top back to 0.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= !w_accept && (r_state == ST_SCAN) && (r_cnt == '0) && (&r_idx);
    end
  end

  assign o_wrap = r_wrap;
`else
  assign o_wrap = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Bench for onehot_decoder_seq: directed scenarios plus random traffic vs a timeline model.
// Scan checks follow DECODER_SCAN_EN the same way the design does.
module tb_onehot_decoder_seq;

  localparam int unsigned SEL_W     = 2;
  localparam int unsigned PULSE_LEN = 4;
  localparam int unsigned DWELL     = 8;
  localparam int          N         = 1 << SEL_W;
  localparam int          VW        = N + SEL_W + 3;
`ifdef DECODER_SCAN_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif

  localparam int K_IDLE  = 0;
  localparam int K_HOLD  = 1;
  localparam int K_PULSE = 2;
  localparam int K_SCAN  = 3;

  logic              i_clk;
  logic              i_rst;
  logic              i_en;
  logic [1:0]        i_mode;
  logic [SEL_W-1:0]  i_in;
  logic              i_load;
  logic              o_ready;
  logic [N-1:0]      o_out;
  logic [SEL_W-1:0]  o_out_idx;
  logic              o_busy;
  logic              o_wrap;
  logic [VW-1:0]     w_dut;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: what is being shown, where it started, and cycles since the load.
  int m_kind  = K_IDLE;
  int m_start = 0;
  int m_t     = 0;

  onehot_decoder_seq #(
    .SEL_W(SEL_W), .PULSE_LEN(PULSE_LEN), .DWELL(DWELL)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_mode(i_mode), .i_in(i_in),
    .i_load(i_load), .o_ready(o_ready), .o_out(o_out), .o_out_idx(o_out_idx),
    .o_busy(o_busy), .o_wrap(o_wrap)
  );

  assign w_dut = {o_out, o_out_idx, o_busy, o_wrap, o_ready};

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [VW-1:0] exp_vec();
    logic [N-1:0]     o;
    logic [SEL_W-1:0] idx;
    logic             b, w, r;
    int               k;
    o = '0; idx = '0; b = 1'b0; w = 1'b0;
    r = i_en && (m_kind != K_PULSE);
    if (m_kind != K_IDLE) begin
      b = 1'b1;
      k = m_start;
      if (m_kind == K_SCAN) begin
        k = (m_start + m_t / DWELL) % N;
        w = (m_t > 0) && (m_t % DWELL == 0) && (k == 0);
      end
      idx = SEL_W'(k);
      o   = N'(1) << k;
    end
    return {o, idx, b, w, r};
  endfunction

  // Drive one cycle of inputs, take the edge, advance the model, settle.
  task automatic cycle(input logic rst, input logic en, input logic load,
                       input logic [1:0] mode, input logic [SEL_W-1:0] sel);
    logic acc;
    i_rst = rst; i_en = en; i_load = load; i_mode = mode; i_in = sel;
    acc = en && load && (m_kind != K_PULSE);
    @(posedge i_clk);
    if (rst || !en) begin
      m_kind = K_IDLE;
    end else if (acc) begin
      m_start = int'(sel);
      m_t     = 0;
      case (mode)
        2'b00:   m_kind = K_HOLD;
        2'b01:   m_kind = K_PULSE;
        2'b10:   m_kind = SCAN_EN ? K_SCAN : K_IDLE;
        default: m_kind = K_IDLE;
      endcase
    end else if (m_kind == K_PULSE) begin
      m_t++;
      if (m_t == PULSE_LEN) m_kind = K_IDLE;
    end else if (m_kind == K_SCAN) begin
      m_t++;
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 1, 0, 2'b00, 0);
    cycle(1, 1, 1, 2'b01, 3);
    n_tests++;
    if (o_out !== 4'b0000 || o_out_idx !== 2'd0 || o_busy !== 1'b0 || o_wrap !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: out=%b idx=%0d busy=%b wrap=%b ready=%b, expected 0000 0 0 0 1",
               o_out, o_out_idx, o_busy, o_wrap, o_ready);
    end
    cycle(0, 1, 0, 2'b00, 0);
  endtask

  task automatic test_level();
    cycle(0, 1, 1, 2'b00, 2);
    n_tests++;
    if (o_out !== 4'b0100 || o_out_idx !== 2'd2 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL level_load2: out=%b idx=%0d busy=%b, expected 0100 2 1", o_out, o_out_idx, o_busy);
    end
    cycle(0, 1, 1, 2'b00, 3);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 2'b00, 0);
    n_tests++;
    if (o_out !== 4'b1000 || o_out_idx !== 2'd3 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL level_hold3: out=%b idx=%0d busy=%b, expected 1000 3 1", o_out, o_out_idx, o_busy);
    end
    cycle(0, 1, 1, 2'b11, 1);
    n_tests++;
    if (o_out !== 4'b0000 || o_busy !== 1'b0 || o_out_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL level_clear: out=%b idx=%0d busy=%b, expected 0000 0 0", o_out, o_out_idx, o_busy);
    end
  endtask

  task automatic test_pulse();
    int high = 0;
    cycle(0, 1, 1, 2'b01, 1);
    for (int i = 0; i < PULSE_LEN; i++) begin
      n_tests++;
      if (o_out !== 4'b0010 || o_ready !== 1'b0 || o_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL pulse_high[%0d]: out=%b ready=%b busy=%b, expected 0010 0 1", i, o_out, o_ready, o_busy);
      end
      if (o_out === 4'b0010) high++;
      cycle(0, 1, (i == 1), 2'b00, 3);
    end
    n_tests++;
    if (o_out !== 4'b0000 || o_ready !== 1'b1 || o_busy !== 1'b0 || high != PULSE_LEN) begin
      n_fail++;
      $display("FAIL pulse_end: out=%b ready=%b busy=%b high_cycles=%0d, expected 0000 1 0 %0d",
               o_out, o_ready, o_busy, high, PULSE_LEN);
    end
  endtask

  task automatic test_back_to_back();
    cycle(0, 1, 1, 2'b01, 3);
    for (int i = 0; i < PULSE_LEN; i++) cycle(0, 1, 0, 2'b00, 0);
    cycle(0, 1, 1, 2'b01, 0);
    n_tests++;
    if (o_out !== 4'b0001 || o_ready !== 1'b0 || w_dut !== exp_vec()) begin
      n_fail++;
      $display("FAIL back_to_back: out=%b ready=%b, expected 0001 0", o_out, o_ready);
    end
    for (int i = 0; i < PULSE_LEN; i++) cycle(0, 1, 0, 2'b00, 0);
  endtask

`ifdef DECODER_SCAN_EN
  task automatic test_scan();
    int n0100 = 0;
    int nwrap = 0;
    cycle(0, 1, 1, 2'b10, 2);
    for (int i = 0; i <= 3 * DWELL; i++) begin
      n_tests++;
      if (w_dut !== exp_vec()) begin
        n_fail++;
        $display("FAIL scan_step[%0d]: dut=%b expected=%b", i, w_dut, exp_vec());
      end
      if (o_out === 4'b0100) n0100++;
      if (o_wrap === 1'b1) begin
        nwrap++;
        n_tests++;
        if (o_out !== 4'b0001 || i != 2 * DWELL) begin
          n_fail++;
          $display("FAIL scan_wrap_pos: out=%b at %0d, expected 0001 at %0d", o_out, i, 2 * DWELL);
        end
      end
      cycle(0, 1, 0, 2'b00, 0);
    end
    n_tests++;
    if (n0100 != DWELL || nwrap != 1) begin
      n_fail++;
      $display("FAIL scan_counts: dwell_on_2=%0d wraps=%0d, expected %0d 1", n0100, nwrap, DWELL);
    end
    cycle(0, 1, 1, 2'b00, 0);
    for (int i = 0; i < DWELL + 2; i++) cycle(0, 1, 0, 2'b00, 0);
    n_tests++;
    if (o_out !== 4'b0001 || o_busy !== 1'b1 || o_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL scan_preempt: out=%b busy=%b wrap=%b, expected 0001 1 0", o_out, o_busy, o_wrap);
    end
    cycle(0, 1, 1, 2'b10, 0);
    for (int i = 0; i < 2 * DWELL; i++) begin
      n_tests++;
      if (o_wrap !== 1'b0) begin
        n_fail++;
        $display("FAIL scan_from0_wrap[%0d]: wrap=%b expected 0", i, o_wrap);
      end
      cycle(0, 1, 0, 2'b00, 0);
    end
  endtask
`else
  task automatic test_scan_disabled();
    cycle(0, 1, 1, 2'b00, 1);
    cycle(0, 1, 1, 2'b10, 2);
    for (int i = 0; i < 2 * DWELL; i++) begin
      n_tests++;
      if (o_out !== 4'b0000 || o_busy !== 1'b0 || o_wrap !== 1'b0) begin
        n_fail++;
        $display("FAIL scan_disabled[%0d]: out=%b busy=%b wrap=%b, expected 0000 0 0", i, o_out, o_busy, o_wrap);
      end
      cycle(0, 1, 0, 2'b00, 0);
    end
  endtask
`endif

  task automatic test_enable();
    cycle(0, 1, 1, SCAN_EN ? 2'b10 : 2'b00, 1);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 2'b00, 0);
    cycle(0, 0, 1, 2'b00, 3);
    n_tests++;
    if (o_out !== 4'b0000 || o_busy !== 1'b0 || o_ready !== 1'b0 || o_out_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL enable_drop: out=%b busy=%b ready=%b idx=%0d, expected 0000 0 0 0",
               o_out, o_busy, o_ready, o_out_idx);
    end
    cycle(0, 0, 1, 2'b01, 2);
    cycle(0, 1, 0, 2'b00, 0);
    cycle(0, 1, 0, 2'b00, 0);
    n_tests++;
    if (o_out !== 4'b0000 || o_busy !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL enable_return: out=%b busy=%b ready=%b, expected 0000 0 1", o_out, o_busy, o_ready);
    end
  endtask

  task automatic test_random();
    logic rst, en, load;
    for (int i = 0; i < 800; i++) begin
      rst  = ($urandom_range(0, 59) == 0);
      en   = ($urandom_range(0, 11) != 0);
      load = ($urandom_range(0, 6) == 0);
      cycle(rst, en, load, 2'($urandom_range(0, 3)), SEL_W'($urandom_range(0, N - 1)));
      n_tests++;
      if (w_dut !== exp_vec() || $countones(o_out) > 1) begin
        n_fail++;
        $display("FAIL random[%0d]: dut=%b expected=%b", i, w_dut, exp_vec());
      end
    end
  endtask

  initial begin
    i_rst = 1'b1; i_en = 1'b1; i_load = 1'b0; i_mode = 2'b00; i_in = '0;
    test_reset();
    test_level();
    test_pulse();
    test_back_to_back();
`ifdef DECODER_SCAN_EN
    test_scan();
`else
    test_scan_disabled();
`endif
    test_enable();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
